// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking,
// frame-start and divided game-tick strobes, all advancing on pix_en.
module vga_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_en,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start,
   output logic       game_tick
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_BLANK   = 10'(V_ACTIVE);
   // Decode bounds are 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
   localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [7:0]  TICK_LAST = 8'(TICK_DIV - 1);

   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic [7:0] tick_cnt_q, tick_cnt_d;
   logic       hsync_q, vsync_q, video_on_q, frame_start_q, game_tick_q;
   logic       hsync_d, vsync_d, video_on_d;
   logic       at_origin, at_vblank, tick_wrap;

   always_comb begin
      x_d = (x_q == H_LAST) ? '0 : x_q + 10'd1;
      y_d = y_q;
      if (x_q == H_LAST) begin
         y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end

      // Decode from the next position so the flags line up with x_pos/y_pos.
      hsync_d    = !(({1'b0, x_d} >= HS_START) && ({1'b0, x_d} < HS_END));
      vsync_d    = !(({1'b0, y_d} >= VS_START) && ({1'b0, y_d} < VS_END));
      video_on_d = ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);

      at_origin = (x_d == '0) && (y_d == '0);
      at_vblank = (x_d == '0) && (y_d == V_BLANK);
      tick_wrap = (tick_cnt_q == TICK_LAST);

      tick_cnt_d = tick_cnt_q;
      if (at_vblank) begin
         tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q           <= '0;
         y_q           <= '0;
         tick_cnt_q    <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         video_on_q    <= 1'b1;
         frame_start_q <= 1'b0;
         game_tick_q   <= 1'b0;
      end else if (pix_en) begin
         x_q           <= x_d;
         y_q           <= y_d;
         tick_cnt_q    <= tick_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= at_origin;
         game_tick_q   <= at_vblank && tick_wrap;
      end else begin
         frame_start_q <= 1'b0;
         game_tick_q   <= 1'b0;
      end
   end

   assign x_pos       = x_q;
   assign y_pos       = y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign game_tick   = game_tick_q;

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter TICK_DIV, 1, frames per game_tick; legal range 1..255.
REQ-010 clk  input  1  single system clock; all logic on its rising edge.
REQ-011 reset_n  input  1  asynchronous, active-low reset.
REQ-012 pix_en  input  1  pixel-advance enable, one clk wide per pixel (e.g. every 2nd clk for 25 MHz from 50 MHz).
REQ-013 x_pos  output  10  current horizontal count, 0..H_TOTAL-1; feeds the game/movement pixel inputs.
REQ-014 y_pos  output  10  current vertical count, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, active-low.
REQ-016 vsync  output  1  vertical sync, active-low.
REQ-017 video_on  output  1  high when x_pos < H_ACTIVE and y_pos < V_ACTIVE.
REQ-018 frame_start  output  1  one-clk pulse when counters reach (0,0).
REQ-019 game_tick  output  1  one-clk pulse at start of vertical blank, every TICK_DIV frames; replaces free-running game clock divider.

Function
REQ-020 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 default).
REQ-021 On a clk edge with pix_en=1: x_pos increments; at H_TOTAL-1 it wraps to 0 and y_pos increments; y_pos at V_TOTAL-1 wraps to 0 together with x_pos.
REQ-022 On a clk edge with pix_en=0: x_pos, y_pos, hsync, vsync, video_on hold; frame_start and game_tick are 0.
REQ-023 All outputs are registers; hsync, vsync, video_on are decoded from the next counter value so they always match x_pos/y_pos of the same cycle (zero relative latency).
REQ-024 hsync=0 iff H_ACTIVE+H_FP <= x_pos < H_ACTIVE+H_FP+H_SYNC (656..751 default), else 1.
REQ-025 vsync=0 iff V_ACTIVE+V_FP <= y_pos < V_ACTIVE+V_FP+V_SYNC (490..491 default), else 1.
REQ-026 frame_start=1 for exactly the clk cycle following a pix_en step that wraps counters to (0,0); never asserted by reset alone.
REQ-027 Frame-tick counter (8-bit) advances on each pix_en step into (x=0, y=V_ACTIVE); when it equals TICK_DIV-1, game_tick pulses for that following cycle and counter returns to 0.
REQ-028 game_tick and frame_start never assert in the same cycle (different counter positions).
REQ-029 Counter widths: 10 bits each; parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.
REQ-030 pix_en asserted on consecutive clk cycles is legal; each asserted cycle is one pixel step.

Reset
REQ-031 reset_n=0 asynchronously forces x_pos=0, y_pos=0, hsync=1, vsync=1, video_on=1, frame_start=0, game_tick=0, frame-tick counter=0.
REQ-032 Reset asserted mid-frame discards position; after release the first pix_en step yields x_pos=1, y_pos=0.
REQ-033 No output pulses on reset release without a pix_en step.

Verification
REQ-034 Reset release, pix_en every 2nd clk, 1 frame -> 420000 pix_en steps per frame; frame_start pulses once at return to (0,0).
REQ-035 Line scan -> hsync low exactly for x_pos 656..751 (96 steps); video_on falls at x_pos=640 and rises at x_pos=0 on rows <480.
REQ-036 Frame scan -> vsync low exactly for y_pos 490..491; video_on=0 for all x_pos on rows 480..524.
REQ-037 TICK_DIV=3, run 7 frames -> game_tick pulses 2 times, each on the cycle counters reach (0,480), one clk wide.
REQ-038 pix_en held low 100 clks at (x=799,y=524) -> outputs hold, no pulses; next pix_en -> (0,0) and frame_start=1.
REQ-039 reset_n pulsed low at (x=300,y=200) between clk edges -> outputs reset immediately without waiting for clk; next pix_en -> x_pos=1, y_pos=0.
